// File: rtl/sfu_pkg.sv
// Shared definitions for the SFU output-drain path: default geometry,
// drain FSM state encoding and the signed lane type.
package sfu_pkg;

    localparam int SFU_COL     = 8;
    localparam int SFU_BW      = 4;
    localparam int SFU_NIJ_LEN = 36;

    typedef enum logic [1:0] {
        SFU_DRAIN_IDLE  = 2'd0,
        SFU_DRAIN_WRITE = 2'd1,
        SFU_DRAIN_DONE  = 2'd2
    } drain_state_e;

    typedef logic signed [SFU_BW-1:0] lane_t;

endpackage

// File: rtl/sfu_drain_relu_lane.sv
// Single-lane ReLU: clamps negative two's-complement values to zero when enabled,
// otherwise passes the lane through unchanged.
module relu_lane
    import sfu_pkg::*;
#(
    parameter int bw = SFU_BW
) (
    input  logic              relu_en,
    input  logic signed [bw-1:0] value,
    output logic signed [bw-1:0] result
);

    assign result = (relu_en && value[bw-1]) ? '0 : value;

endmodule

// File: rtl/sfu_drain.sv
// Drains the SFU row output stream into the output SRAM: one write per valid
// beat at base_addr + count, optional ReLU, done after nij_len writes.
module sfu_drain
    import sfu_pkg::*;
#(
    parameter int col     = SFU_COL,
    parameter int bw      = SFU_BW,
    parameter int nij_len = SFU_NIJ_LEN,
    parameter int aw      = 6
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [col-1:0][bw-1:0]      in,
    input  logic                        i_valid,
    input  logic                        relu_en,
    input  logic [aw-1:0]               base_addr,
    input  logic                        clear,
    output logic                        sram_cen,
    output logic                        sram_wen,
    output logic [aw-1:0]               sram_addr,
    output logic [col-1:0][bw-1:0]      sram_d,
    output logic                        done,
    output logic [$clog2(nij_len):0]    wr_count
);

    localparam int cw = $clog2(nij_len) + 1;
    localparam logic [cw-1:0] last_count = cw'(nij_len);

    drain_state_e              state;
    logic [aw-1:0]             base_q;
    logic [aw-1:0]             next_addr;
    logic [col-1:0][bw-1:0]    relu_word;

    for (genvar i = 0; i < col; i++) begin : g_lane
        relu_lane #(.bw(bw)) u_relu (
            .relu_en (relu_en),
            .value   (in[i]),
            .result  (relu_word[i])
        );
    end

    // Truncation to aw bits gives the modulo-2^aw address wrap.
    assign next_addr = base_q + aw'(wr_count);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SFU_DRAIN_IDLE;
            base_q    <= '0;
            sram_cen  <= 1'b1;
            sram_wen  <= 1'b1;
            sram_addr <= '0;
            sram_d    <= '0;
            done      <= 1'b0;
            wr_count  <= '0;
        end else begin
            // Enables default to idle; sram_addr/sram_d hold between writes.
            sram_cen <= 1'b1;
            sram_wen <= 1'b1;
            if (clear) begin
                state    <= SFU_DRAIN_IDLE;
                wr_count <= '0;
                done     <= 1'b0;
            end else begin
                unique case (state)
                    SFU_DRAIN_IDLE: begin
                        if (i_valid) begin
                            base_q    <= base_addr;
                            sram_addr <= base_addr;
                            sram_d    <= relu_word;
                            sram_cen  <= 1'b0;
                            sram_wen  <= 1'b0;
                            wr_count  <= cw'(1);
                            if (nij_len == 1) begin
                                state <= SFU_DRAIN_DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= SFU_DRAIN_WRITE;
                            end
                        end
                    end
                    SFU_DRAIN_WRITE: begin
                        // The cycle after the final write retires to DONE and drops any beat.
                        if (wr_count == last_count) begin
                            state <= SFU_DRAIN_DONE;
                            done  <= 1'b1;
                        end else if (i_valid) begin
                            sram_addr <= next_addr;
                            sram_d    <= relu_word;
                            sram_cen  <= 1'b0;
                            sram_wen  <= 1'b0;
                            wr_count  <= wr_count + cw'(1);
                        end
                    end
                    SFU_DRAIN_DONE: begin
                        state <= SFU_DRAIN_DONE;
                    end
                    default: begin
                        state <= SFU_DRAIN_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sfu_drain.sv
// Self-checking bench for sfu_drain: directed scenarios plus random traffic,
// compared cycle by cycle against a count-based reference model.
module tb_sfu_drain;
    import sfu_pkg::*;

    localparam int COL = 8;
    localparam int BW  = 4;
    localparam int NIJ = 36;
    localparam int AW  = 6;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [COL-1:0][BW-1:0] din;
    logic                   i_valid;
    logic                   relu_en;
    logic [AW-1:0]          base_addr;
    logic                   clear;
    logic                   sram_cen;
    logic                   sram_wen;
    logic [AW-1:0]          sram_addr;
    logic [COL-1:0][BW-1:0] sram_d;
    logic                   done;
    logic [$clog2(NIJ):0]   wr_count;

    sfu_drain #(.col(COL), .bw(BW), .nij_len(NIJ), .aw(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (din),
        .i_valid   (i_valid),
        .relu_en   (relu_en),
        .base_addr (base_addr),
        .clear     (clear),
        .sram_cen  (sram_cen),
        .sram_wen  (sram_wen),
        .sram_addr (sram_addr),
        .sram_d    (sram_d),
        .done      (done),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: drain progress is just the number of writes so far.
    int          m_count;
    int          m_base;
    logic        e_cen;
    logic [5:0]  e_addr;
    logic [31:0] e_d;
    logic        e_done;
    logic [47:0] exp_vec;
    logic [47:0] obs_vec;
    int          obs_writes;

    function automatic logic [31:0] relu_model(input logic [31:0] w, input logic r);
        logic [31:0] o;
        for (int i = 0; i < COL; i++) begin
            lane_t ln;
            ln = lane_t'(w[i*BW +: BW]);
            o[i*BW +: BW] = (r && ln < 0) ? 4'd0 : w[i*BW +: BW];
        end
        return o;
    endfunction

    function automatic logic [31:0] lanes_ramp();
        logic [31:0] o;
        for (int i = 0; i < COL; i++) o[i*BW +: BW] = 4'(i);
        return o;
    endfunction

    function automatic logic [31:0] lanes_alt();
        logic [31:0] o;
        for (int i = 0; i < COL; i++) o[i*BW +: BW] = (i % 2 == 0) ? 4'hD : 4'h5;
        return o;
    endfunction

    // One clock cycle: drive at negedge, advance the model at posedge, sample #1 later.
    task automatic cycle(input logic v, input logic [31:0] w, input logic r,
                         input logic [5:0] b, input logic c, input logic rst);
        @(negedge clk);
        i_valid = v; din = w; relu_en = r; base_addr = b; clear = c; reset = rst;
        @(posedge clk);
        e_cen = 1'b1;
        if (rst) begin
            m_count = 0; m_base = 0; e_done = 1'b0; e_addr = '0; e_d = '0;
        end else if (c) begin
            m_count = 0; e_done = 1'b0;
        end else if (e_done) begin
            e_done = 1'b1;
        end else if (m_count == NIJ) begin
            e_done = 1'b1;
        end else if (v) begin
            if (m_count == 0) m_base = int'(b);
            e_addr  = 6'((m_base + m_count) % 64);
            e_d     = relu_model(w, r);
            e_cen   = 1'b0;
            m_count = m_count + 1;
        end
        #1;
        exp_vec = {e_cen, e_cen, e_addr, e_d, e_done, 7'(m_count)};
        obs_vec = {sram_cen, sram_wen, sram_addr, sram_d, done, wr_count};
        if (sram_cen === 1'b0) obs_writes++;
    endtask

    task automatic test_reset();
        cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 6'h11, 1'b0, 1'b1);
        total++;
        if (obs_vec !== 48'hC000_0000_0000) begin
            bad++; $display("FAIL reset: got %h want %h", obs_vec, 48'hC000_0000_0000);
        end
        cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_sequential();
        obs_writes = 0;
        for (int k = 0; k < NIJ + 3; k++) begin
            cycle(k < NIJ, lanes_ramp(), 1'b0, 6'h04, 1'b0, 1'b0);
            total++;
            if (obs_vec !== exp_vec) begin
                bad++; $display("FAIL seq cyc %0d: got %h want %h", k, obs_vec, exp_vec);
            end
            if (k == NIJ - 1) begin
                total++;
                if (sram_addr !== 6'h27 || done !== 1'b0) begin
                    bad++; $display("FAIL seq_last: addr=%h done=%b want addr=27 done=0", sram_addr, done);
                end
            end
        end
        total++;
        if (obs_writes !== NIJ || wr_count !== 7'd36 || done !== 1'b1) begin
            bad++; $display("FAIL seq_end: writes=%0d cnt=%0d done=%b want 36/36/1", obs_writes, wr_count, done);
        end
    endtask

    task automatic test_relu();
        cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < NIJ + 2; k++) begin
            cycle(k < NIJ, lanes_alt(), 1'b1, 6'h04, 1'b0, 1'b0);
            total++;
            if (obs_vec !== exp_vec) begin
                bad++; $display("FAIL relu cyc %0d: got %h want %h", k, obs_vec, exp_vec);
            end
        end
        total++;
        if (sram_d !== 32'h5050_5050) begin
            bad++; $display("FAIL relu_data: got %h want 50505050", sram_d);
        end
    endtask

    task automatic test_overrun();
        cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        obs_writes = 0;
        for (int k = 0; k < 50; k++) begin
            cycle(1'b1, $urandom, 1'($urandom), 6'($urandom), 1'b0, 1'b0);
            total++;
            if (obs_vec !== exp_vec) begin
                bad++; $display("FAIL overrun cyc %0d: got %h want %h", k, obs_vec, exp_vec);
            end
        end
        total++;
        if (obs_writes !== NIJ || done !== 1'b1) begin
            bad++; $display("FAIL overrun_count: writes=%0d done=%b want 36/1", obs_writes, done);
        end
    endtask

    task automatic test_gap();
        logic [5:0] b;
        int beat;
        b = 6'($urandom);
        beat = 0;
        cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        obs_writes = 0;
        for (int k = 0; k < NIJ + 5; k++) begin
            logic v;
            v = (k < 10) || (k >= 13 && k < NIJ + 3);
            if (v) beat++;
            cycle(v, $urandom, 1'($urandom), b, 1'b0, 1'b0);
            total++;
            if (obs_vec !== exp_vec) begin
                bad++; $display("FAIL gap cyc %0d: got %h want %h", k, obs_vec, exp_vec);
            end
            if (v && beat == 11) begin
                total++;
                if (sram_addr !== 6'(b + 6'd10) || sram_cen !== 1'b0) begin
                    bad++; $display("FAIL gap_beat11: addr=%h cen=%b want %h/0", sram_addr, sram_cen, 6'(b + 6'd10));
                end
            end
        end
        total++;
        if (obs_writes !== NIJ) begin
            bad++; $display("FAIL gap_count: writes=%0d want 36", obs_writes);
        end
    endtask

    task automatic test_clear_mid();
        logic [5:0] nb;
        nb = 6'h2A;
        cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 19; k++) begin
            cycle(1'b1, $urandom, 1'b0, 6'h10, 1'b0, 1'b0);
            total++;
            if (obs_vec !== exp_vec) begin
                bad++; $display("FAIL clear cyc %0d: got %h want %h", k, obs_vec, exp_vec);
            end
        end
        cycle(1'b1, $urandom, 1'b0, 6'h10, 1'b1, 1'b0);
        total++;
        if (wr_count !== 7'd0 || sram_cen !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL clear_drop: cnt=%0d cen=%b done=%b want 0/1/0", wr_count, sram_cen, done);
        end
        cycle(1'b1, 32'h1234_5670, 1'b0, nb, 1'b0, 1'b0);
        total++;
        if (sram_addr !== nb || wr_count !== 7'd1 || sram_d !== 32'h1234_5670) begin
            bad++; $display("FAIL clear_rearm: addr=%h cnt=%0d d=%h want 2a/1/12345670", sram_addr, wr_count, sram_d);
        end
    endtask

    task automatic test_wrap_reset();
        cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, $urandom, 1'($urandom), 6'h3E, 1'b0, 1'b0);
            total++;
            if (obs_vec !== exp_vec) begin
                bad++; $display("FAIL wrap cyc %0d: got %h want %h", k, obs_vec, exp_vec);
            end
            if (k == 2) begin
                total++;
                if (sram_addr !== 6'h00) begin
                    bad++; $display("FAIL wrap_third: addr=%h want 00", sram_addr);
                end
            end
        end
        cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 6'h3E, 1'b0, 1'b1);
        total++;
        if (obs_vec !== 48'hC000_0000_0000) begin
            bad++; $display("FAIL mid_reset: got %h want %h", obs_vec, 48'hC000_0000_0000);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            cycle($urandom_range(0, 3) != 0, $urandom, 1'($urandom), 6'($urandom),
                  $urandom_range(0, 59) == 0, $urandom_range(0, 149) == 0);
            total++;
            if (obs_vec !== exp_vec) begin
                bad++; $display("FAIL random cyc %0d: got %h want %h", k, obs_vec, exp_vec);
            end
        end
    endtask

    initial begin
        reset = 1'b1; din = '0; i_valid = 1'b0; relu_en = 1'b0;
        base_addr = '0; clear = 1'b0;
        m_count = 0; m_base = 0; e_cen = 1'b1; e_addr = '0; e_d = '0; e_done = 1'b0;
        obs_writes = 0;
        test_reset();
        test_sequential();
        test_relu();
        test_overrun();
        test_gap();
        test_clear_mid();
        test_wrap_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
